// File: rtl/vec_data_mem_sequencer_if.sv
// Avalon-MM data-memory master bus between the vector memory sequencer and memory.
`timescale 1ns/1ps
interface vec_data_mem_sequencer_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_waitrequest, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_readdata, avm_waitrequest, avm_readdatavalid
    );
endinterface

// File: rtl/vec_data_mem_sequencer.sv
// Splits scalar/128-bit memory-stage accesses into 32-bit Avalon-MM beats and stalls the pipeline meanwhile.
`timescale 1ns/1ps
module vec_data_mem_sequencer #(
    parameter int VEC_BEATS      = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_mem_read,
    input  logic                      i_mem_write,
    input  logic                      i_mem_vector_op,
    input  logic [31:0]               i_mem_addr,
    input  logic [32*VEC_BEATS-1:0]   i_mem_wdata,
    output logic [32*VEC_BEATS-1:0]   o_mem_rdata,
    output logic                      o_stall_all,
    output logic                      o_err_timeout,
    input  logic                      i_err_clear,
    vec_data_mem_sequencer_if.master  avm
);
    localparam int BW = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] LAST_VEC = BW'(VEC_BEATS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]               r_state;
    logic [BW-1:0]            r_beat;
    logic [TW-1:0]            r_tmo;
    logic                     r_vec;
    logic                     r_is_write;
    logic [32*VEC_BEATS-1:0]  r_wdata;
    logic [32*VEC_BEATS-1:0]  r_rdata;
    logic                     r_err;
    logic [31:0]              r_avm_address;
    logic                     r_avm_read;
    logic                     r_avm_write;
    logic [31:0]              r_avm_writedata;

    logic                     w_req;
    logic                     w_last;
    logic [BW-1:0]            w_beat_nxt;
    logic                     w_timeout;

    assign w_req      = i_mem_read | i_mem_write;
    assign w_last     = r_vec ? (r_beat == LAST_VEC) : (r_beat == {BW{1'b0}});
    assign w_beat_nxt = r_beat + 1'b1;
    // A beat is abandoned only on its final allowed cycle if it made no progress then.
    assign w_timeout  = (r_tmo == TMO_LAST) &
                        (((r_state == S_ISSUE) & avm.avm_waitrequest) |
                         ((r_state == S_WAIT_RD) & ~avm.avm_readdatavalid));

    assign o_stall_all = reset & (((r_state == S_IDLE) & w_req) |
                                  (r_state == S_ISSUE) | (r_state == S_WAIT_RD));
    assign o_mem_rdata        = r_rdata;
    assign o_err_timeout      = r_err;
    assign avm.avm_address    = r_avm_address;
    assign avm.avm_read       = r_avm_read;
    assign avm.avm_write      = r_avm_write;
    assign avm.avm_writedata  = r_avm_writedata;
    assign avm.avm_byteenable = 4'b1111;

    // Access sequencing, beat/timeout counters, registered bus command and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_beat          <= {BW{1'b0}};
            r_tmo           <= {TW{1'b0}};
            r_vec           <= 1'b0;
            r_is_write      <= 1'b0;
            r_wdata         <= {(32*VEC_BEATS){1'b0}};
            r_rdata         <= {(32*VEC_BEATS){1'b0}};
            r_err           <= 1'b0;
            r_avm_address   <= 32'd0;
            r_avm_read      <= 1'b0;
            r_avm_write     <= 1'b0;
            r_avm_writedata <= 32'd0;
        end else begin
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (i_err_clear) begin
                r_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_state         <= S_ISSUE;
                        r_beat          <= {BW{1'b0}};
                        r_tmo           <= {TW{1'b0}};
                        r_vec           <= i_mem_vector_op;
                        r_is_write      <= i_mem_write;
                        r_wdata         <= i_mem_wdata;
                        r_rdata         <= {(32*VEC_BEATS){1'b0}};
                        r_avm_address   <= i_mem_addr & 32'hFFFF_FFFC;
                        r_avm_writedata <= i_mem_wdata[31:0];
                        r_avm_write     <= i_mem_write;
                        r_avm_read      <= ~i_mem_write;
                    end
                end
                S_ISSUE: begin
                    if (!avm.avm_waitrequest) begin
                        r_tmo <= {TW{1'b0}};
                        if (!r_is_write) begin
                            r_avm_read <= 1'b0;
                            r_state    <= S_WAIT_RD;
                        end else if (w_last) begin
                            r_avm_write <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            r_beat          <= w_beat_nxt;
                            r_avm_address   <= r_avm_address + 32'd4;
                            r_avm_writedata <= r_wdata[{w_beat_nxt, 5'd0} +: 32];
                        end
                    end else if (w_timeout) begin
                        r_avm_read  <= 1'b0;
                        r_avm_write <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_WAIT_RD: begin
                    if (avm.avm_readdatavalid) begin
                        r_rdata[{r_beat, 5'd0} +: 32] <= avm.avm_readdata;
                        r_tmo <= {TW{1'b0}};
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_beat        <= w_beat_nxt;
                            r_avm_address <= r_avm_address + 32'd4;
                            r_avm_read    <= 1'b1;
                            r_state       <= S_ISSUE;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_DONE: begin
                    r_tmo   <= {TW{1'b0}};
                    r_state <= S_IDLE;
                end
                default: begin
                    r_avm_read  <= 1'b0;
                    r_avm_write <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vec_data_mem_sequencer.sv
// Directed bench for vec_data_mem_sequencer with a small Avalon-MM responder and command monitor.
`timescale 1ns/1ps
module tb_vec_data_mem_sequencer;
    logic         clk;
    logic         reset;
    logic         mem_read, mem_write, mem_vector_op, err_clear;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         stall, err;

    vec_data_mem_sequencer_if avm_if ();

    vec_data_mem_sequencer #(.VEC_BEATS(4), .TIMEOUT_CYCLES(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_mem_read      (mem_read),
        .i_mem_write     (mem_write),
        .i_mem_vector_op (mem_vector_op),
        .i_mem_addr      (mem_addr),
        .i_mem_wdata     (mem_wdata),
        .o_mem_rdata     (mem_rdata),
        .o_stall_all     (stall),
        .o_err_timeout   (err),
        .i_err_clear     (err_clear),
        .avm             (avm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass, n_total, stall_cnt;
    bit          auto_rsp;
    logic [31:0] rsp_q[$];
    logic [31:0] cmd_addr_q[$];
    logic [31:0] cmd_data_q[$];
    bit          cmd_wr_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (stall && n < 40);
        check(tag, stall, 1'b0);
    endtask

    task automatic clear_log();
        cmd_addr_q.delete();
        cmd_data_q.delete();
        cmd_wr_q.delete();
        stall_cnt = 0;
    endtask

    // Monitor accepted commands and return read data one cycle after an accepted read.
    initial begin
        bit          pend;
        logic [31:0] pend_d;
        pend = 1'b0;
        pend_d = 32'd0;
        avm_if.avm_readdatavalid = 1'b0;
        avm_if.avm_readdata = 32'd0;
        forever begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if ((avm_if.avm_read || avm_if.avm_write) && !avm_if.avm_waitrequest) begin
                cmd_addr_q.push_back(avm_if.avm_address);
                cmd_data_q.push_back(avm_if.avm_writedata);
                cmd_wr_q.push_back(avm_if.avm_write);
            end
            avm_if.avm_readdatavalid = pend;
            avm_if.avm_readdata = pend_d;
            pend = auto_rsp && avm_if.avm_read && !avm_if.avm_waitrequest;
            pend_d = (pend && rsp_q.size() > 0) ? rsp_q.pop_front() : 32'd0;
        end
    end

    initial begin
        logic [31:0] exp_a[4];
        logic [31:0] exp_d[4];
        n_pass = 0; n_total = 0; stall_cnt = 0; auto_rsp = 1'b1;
        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_vector_op = 1'b0;
        mem_addr = 32'd0; mem_wdata = 128'd0; err_clear = 1'b0;
        avm_if.avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst read", avm_if.avm_read, 1'b0);
        check("rst write", avm_if.avm_write, 1'b0);
        check("rst addr", avm_if.avm_address, 32'd0);
        check("rst rdata", mem_rdata, 128'd0);
        check("rst err", err, 1'b0);
        mem_read = 1'b1;
        #1;
        check("rst stall with req", stall, 1'b0);
        mem_read = 1'b0;
        reset = 1'b1;
        cyc();
        check("idle stall", stall, 1'b0);
        check("byteenable", avm_if.avm_byteenable, 4'hF);

        // Scalar read at 0x100
        clear_log();
        rsp_q.push_back(32'hDEADBEEF);
        mem_read = 1'b1; mem_addr = 32'h100; mem_vector_op = 1'b0;
        wait_done("t1 done");
        check("t1 rdata", mem_rdata, {96'd0, 32'hDEADBEEF});
        mem_read = 1'b0;
        cyc();
        check("t1 rdata hold", mem_rdata, {96'd0, 32'hDEADBEEF});
        check("t1 stall cycles", stall_cnt, 3);
        check("t1 ncmd", cmd_addr_q.size(), 1);
        check("t1 addr", cmd_addr_q[0], 32'h100);
        check("t1 is read", cmd_wr_q[0], 1'b0);

        // Vector write at 0x203, two wait cycles on beat 1
        clear_log();
        mem_write = 1'b1; mem_vector_op = 1'b1; mem_addr = 32'h203;
        mem_wdata = 128'h00000044_00000033_00000022_00000011;
        cyc();
        cyc();
        avm_if.avm_waitrequest = 1'b1;
        check("t2 b1 addr", avm_if.avm_address, 32'h204);
        check("t2 b1 data", avm_if.avm_writedata, 32'h22);
        cyc();
        check("t2 hold addr", avm_if.avm_address, 32'h204);
        check("t2 hold data", avm_if.avm_writedata, 32'h22);
        check("t2 hold write", avm_if.avm_write, 1'b1);
        cyc();
        avm_if.avm_waitrequest = 1'b0;
        wait_done("t2 done");
        mem_write = 1'b0;
        cyc();
        check("t2 stall cycles", stall_cnt, 7);
        check("t2 ncmd", cmd_addr_q.size(), 4);
        exp_a = '{32'h200, 32'h204, 32'h208, 32'h20C};
        exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2 addr%0d", i), cmd_addr_q[i], exp_a[i]);
            check($sformatf("t2 data%0d", i), cmd_data_q[i], exp_d[i]);
            check($sformatf("t2 wr%0d", i), cmd_wr_q[i], 1'b1);
        end

        // Vector read wrapping past 2^32
        clear_log();
        rsp_q = '{32'hA, 32'hB, 32'hC, 32'hD};
        mem_read = 1'b1; mem_vector_op = 1'b1; mem_addr = 32'hFFFF_FFF8;
        wait_done("t3 done");
        check("t3 rdata", mem_rdata, {32'hD, 32'hC, 32'hB, 32'hA});
        mem_read = 1'b0;
        cyc();
        check("t3 stall cycles", stall_cnt, 9);
        check("t3 ncmd", cmd_addr_q.size(), 4);
        exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        for (int i = 0; i < 4; i++)
            check($sformatf("t3 addr%0d", i), cmd_addr_q[i], exp_a[i]);

        // Read with no readdatavalid: timeout after 8 cycles in WAIT_RD
        clear_log();
        auto_rsp = 1'b0;
        mem_read = 1'b1; mem_vector_op = 1'b0; mem_addr = 32'h40;
        wait_done("t4 done");
        check("t4 err set", err, 1'b1);
        check("t4 rdata zero", mem_rdata, 128'd0);
        check("t4 read dropped", avm_if.avm_read, 1'b0);
        mem_read = 1'b0;
        cyc();
        check("t4 stall cycles", stall_cnt, 10);
        check("t4 err sticky", err, 1'b1);
        err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;
        check("t4 err cleared", err, 1'b0);
        auto_rsp = 1'b1;

        // Reset during beat 2 of a vector read
        clear_log();
        rsp_q = '{32'h1, 32'h2, 32'h3, 32'h4};
        mem_read = 1'b1; mem_vector_op = 1'b1; mem_addr = 32'h300;
        repeat (5) cyc();
        check("t5 b2 read", avm_if.avm_read, 1'b1);
        check("t5 b2 addr", avm_if.avm_address, 32'h308);
        reset = 1'b0;
        #1;
        check("t5 rst read", avm_if.avm_read, 1'b0);
        check("t5 rst stall", stall, 1'b0);
        mem_read = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        rsp_q.delete();
        cyc();
        check("t5 post stall", stall, 1'b0);
        check("t5 post rdata", mem_rdata, 128'd0);
        check("t5 post addr", avm_if.avm_address, 32'd0);

        // Back-to-back scalar writes, first with read and write both high
        clear_log();
        mem_read = 1'b1; mem_write = 1'b1; mem_vector_op = 1'b0; mem_addr = 32'h500;
        mem_wdata = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_12345678;
        wait_done("t6 done1");
        mem_read = 1'b0; mem_write = 1'b1; mem_addr = 32'h504;
        mem_wdata = 128'h0000_0000_0000_0000_0000_0000_9ABC_DEF0;
        cyc();
        check("t6 accept stall", stall, 1'b1);
        cyc();
        check("t6 second write", avm_if.avm_write, 1'b1);
        check("t6 second addr", avm_if.avm_address, 32'h504);
        wait_done("t6 done2");
        mem_write = 1'b0;
        cyc();
        check("t6 stall cycles", stall_cnt, 4);
        check("t6 ncmd", cmd_addr_q.size(), 2);
        check("t6 addr0", cmd_addr_q[0], 32'h500);
        check("t6 data0", cmd_data_q[0], 32'h12345678);
        check("t6 wr0", cmd_wr_q[0], 1'b1);
        check("t6 addr1", cmd_addr_q[1], 32'h504);
        check("t6 data1", cmd_data_q[1], 32'h9ABCDEF0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
